pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the architectural fetch PC and sequences it into instruction fetch over a valid/ready handshake.
- On sequential flow it advances the PC by 4. On a branch/jump redirect from execute it loads the branch target (base + immediate).
- Supports pipeline stall, halt/resume and flush signalling.
- Sits between the execute-stage branch resolution logic and the instruction memory/fetch stage.

Parameters:
- BITSIZE, 32, width of PC, base, offset and target.
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on misaligned target (only with MISALIGN_TRAP_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- FetchReady  in  1  fetch stage accepts FetchPC this cycle.
- FetchValid  out  1  FetchPC is a valid request.
- FetchPC  out  BITSIZE  current fetch address.
- Stall  in  1  hold PC, deassert FetchValid.
- RedirectValid  in  1  taken branch/jump resolved this cycle.
- RedirectBase  in  BITSIZE  PC of branch (or rs1 for JALR).
- RedirectOffset  in  BITSIZE  sign-extended immediate, byte offset, no shift.
- Flush  out  1  registered one-cycle pulse: squash in-flight fetches.
- Halt  in  1  request halt.
- Resume  in  1  leave HALTED.
- Halted  out  1  high in HALTED state.
- Trap  out  1  registered one-cycle pulse on misaligned redirect (0 when macro off).

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high on reset.
- Reset values: FetchPC=RESET_VECTOR, FetchValid=0, Flush=0, Halted=0, Trap=0, state=BOOT.
- States:
  - BOOT: lasts exactly one cycle after reset deasserts, FetchValid=0, then goes to RUN.
  - RUN: FetchValid = !Stall.
  - HALTED: FetchValid=0, Halted=1.
- Target computation: target = RedirectBase + RedirectOffset, modulo 2^BITSIZE. Sequential increment is FetchPC + 4, also wrapping; 32'hFFFF_FFFC + 4 = 0.
- Next-PC priority, per cycle in RUN, highest first:
  1. RedirectValid: FetchPC <= target. Flush=1 next cycle. A handshake in the same cycle is discarded (its FetchPC+4 is not applied).
  2. Stall: FetchPC held.
  3. FetchValid && FetchReady: FetchPC <= FetchPC + 4.
  4. Otherwise: hold.
- Stall and the handshake: Stall deasserts FetchValid combinationally, so no handshake can complete while stalled.
- Halt:
  - In RUN with Halt=1 and no redirect, go to HALTED next cycle.
  - A handshake completing in that same cycle still advances the PC.
  - Halt together with a redirect: the redirect is applied and the halt is taken on the same edge.
- HALTED:
  - RedirectValid still updates FetchPC and pulses Flush; the block stays halted.
  - Resume=1 returns to RUN next cycle. Resume is ignored outside HALTED.
  - Halt and Resume both high in HALTED: stay HALTED.
- Reset mid-operation: immediate return to reset values. A pending Flush or Trap pulse is cleared.
- Latency: redirect to new FetchPC with FetchValid is 1 cycle. Handshake to next PC is 1 cycle.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Without the macro: target[1:0] is forced to 2'b00, Trap is tied 0.
- With the macro: a redirect whose target[1:0] != 0 loads TRAP_VECTOR instead, and pulses both Flush and Trap the next cycle. An aligned target behaves as without the macro.

Decomposition:
- Shared package pc_seq_pkg:
  - state enum {BOOT, RUN, HALTED}
  - PC_INCR = 4
  - default RESET_VECTOR / TRAP_VECTOR constants
- Sub-module pc_target_adder: combinational BITSIZE-bit base+offset adder producing target. It is reused by the branch unit, so target arithmetic is defined once.

Test Plan:
1. Sequential fetch: release reset, FetchReady=1 constant. Required: FetchValid=0 in the BOOT cycle, then FetchPC = 0, 4, 8, 12 on consecutive cycles.
2. Redirect with simultaneous handshake: FetchPC=0x10, RedirectValid=1, base=0x10, offset=0xFFFF_FFF8, FetchReady=1. Required: next FetchPC=0x08 (not 0x14), Flush=1 for exactly one cycle.
3. Stall and backpressure:
   - Stall=1 for 3 cycles at PC=0x20. Required: FetchValid=0, PC held at 0x20; on release, FetchValid=1 at PC 0x20.
   - FetchReady=0 for 2 cycles. Required: PC held.
4. Halt/resume:
   - Halt at PC=0x40 with handshake. Required: Halted=1 and PC=0x44 next cycle.
   - Redirect to 0x80 while halted. Required: PC=0x80, still halted.
   - Resume. Required: FetchValid=1 at 0x80 the cycle after.
5. Wrap and reset: PC=0xFFFF_FFFC with a handshake gives PC=0. Assert reset mid-stream between clock edges: outputs take reset values immediately, without waiting for the clock.
6. MISALIGN_TRAP_EN build:
   - Redirect target 0x102. Required: PC=0x100 (TRAP_VECTOR), Trap=1 and Flush=1 for one cycle.
   - Without the macro, the same redirect gives PC=0x100 via masking and Trap=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch PC sequencer and the branch unit.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam int unsigned PC_INCR = 4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_target_adder.sv
// Branch/jump target adder: base + sign-extended byte offset, wrapping modulo 2^BITSIZE.
module pc_target_adder
  import pc_seq_pkg::*;
#(
  parameter int BITSIZE = 32
) (
  input  logic signed [BITSIZE-1:0] base,
  input  logic signed [BITSIZE-1:0] offset,
  output logic signed [BITSIZE-1:0] target
);

  assign target = base + offset;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: BOOT/RUN/HALTED control, redirect, stall and handshake advance.
// Optional misaligned-target trap enabled by defining MISALIGN_TRAP_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                   BITSIZE      = 32,
  parameter logic [BITSIZE-1:0]   RESET_VECTOR = BITSIZE'(DEF_RESET_VECTOR),
  parameter logic [BITSIZE-1:0]   TRAP_VECTOR  = BITSIZE'(DEF_TRAP_VECTOR)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               FetchReady,
  output logic               FetchValid,
  output logic [BITSIZE-1:0] FetchPC,
  input  logic               Stall,
  input  logic               RedirectValid,
  input  logic [BITSIZE-1:0] RedirectBase,
  input  logic [BITSIZE-1:0] RedirectOffset,
  output logic               Flush,
  input  logic               Halt,
  input  logic               Resume,
  output logic               Halted,
  output logic               Trap
);

  state_e             state_p0, state_nxt;
  logic [BITSIZE-1:0] target_raw;
  logic [BITSIZE-1:0] aligned_tgt;
  logic [BITSIZE-1:0] target_eff;
  logic               misaligned;
  logic [BITSIZE-1:0] pc_nxt;
  logic               flush_nxt;
  logic               trap_nxt;

  pc_target_adder #(.BITSIZE(BITSIZE)) u_adder (
    .base   (RedirectBase),
    .offset (RedirectOffset),
    .target (target_raw)
  );

`ifdef MISALIGN_TRAP_EN
  assign misaligned  = (target_raw[1:0] != 2'b00);
  assign aligned_tgt = target_raw;
`else
  // Low bits are silently dropped so the PC can never become misaligned.
  assign misaligned  = 1'b0;
  assign aligned_tgt = target_raw & ~{{(BITSIZE-2){1'b0}}, 2'b11};
`endif
  assign target_eff = misaligned ? TRAP_VECTOR : aligned_tgt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_p0 <= BOOT;
    else       state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p0;
    unique case (state_p0)
      BOOT:    state_nxt = RUN;
      RUN:     if (Halt) state_nxt = HALTED;
      HALTED:  if (Resume && !Halt) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    FetchValid = 1'b0;
    Halted     = 1'b0;
    unique case (state_p0)
      RUN:     FetchValid = !Stall;
      HALTED:  Halted = 1'b1;
      default: ;
    endcase
  end

  // Redirect outranks the handshake; Stall already blocks the handshake via FetchValid.
  always_comb begin
    pc_nxt    = FetchPC;
    flush_nxt = 1'b0;
    trap_nxt  = 1'b0;
    if ((state_p0 != BOOT) && RedirectValid) begin
      pc_nxt    = target_eff;
      flush_nxt = 1'b1;
      trap_nxt  = misaligned;
    end else if (FetchValid && FetchReady) begin
      pc_nxt = FetchPC + BITSIZE'(PC_INCR);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      FetchPC <= RESET_VECTOR;
      Flush   <= 1'b0;
      Trap    <= 1'b0;
    end else begin
      FetchPC <= pc_nxt;
      Flush   <= flush_nxt;
      Trap    <= trap_nxt;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed plan steps then random traffic against a behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        FetchReady, FetchValid, Stall, RedirectValid, Flush, Halt, Resume, Halted, Trap;
  logic [31:0] FetchPC, RedirectBase, RedirectOffset;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  bit          m_boot, m_halted, m_flush, m_trap;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .FetchReady(FetchReady), .FetchValid(FetchValid),
    .FetchPC(FetchPC), .Stall(Stall), .RedirectValid(RedirectValid),
    .RedirectBase(RedirectBase), .RedirectOffset(RedirectOffset), .Flush(Flush),
    .Halt(Halt), .Resume(Resume), .Halted(Halted), .Trap(Trap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] redirect_target(input logic [31:0] b, input logic [31:0] o,
                                                  output bit mis);
    logic [31:0] sum;
    sum = b + o;
`ifdef MISALIGN_TRAP_EN
    mis = (sum % 4) != 0;
    return mis ? TV : sum;
`else
    mis = 1'b0;
    return sum - (sum % 4);
`endif
  endfunction

  // One clock cycle: drive inputs after the falling edge, check, then advance the model.
  task automatic cyc(input logic rv, input logic [31:0] b, input logic [31:0] o,
                     input logic st, input logic rdy, input logic hl, input logic rs);
    bit mis;
    @(negedge clk);
    RedirectValid = rv; RedirectBase = b; RedirectOffset = o;
    Stall = st; FetchReady = rdy; Halt = hl; Resume = rs;
    #1;
    check("pc",     FetchPC,        m_pc);
    check("valid",  32'(FetchValid), 32'(!m_boot && !m_halted && !st));
    check("halted", 32'(Halted),    32'(m_halted));
    check("flush",  32'(Flush),     32'(m_flush));
    check("trap",   32'(Trap),      32'(m_trap));
    if (m_boot) begin
      m_boot = 1'b0; m_flush = 1'b0; m_trap = 1'b0;
    end else begin
      if (rv) begin
        m_pc = redirect_target(b, o, mis);
        m_flush = 1'b1; m_trap = mis;
      end else begin
        m_flush = 1'b0; m_trap = 1'b0;
        if (!m_halted && !st && rdy) m_pc = m_pc + 32'd4;
      end
      if (!m_halted) m_halted = hl;
      else if (rs && !hl) m_halted = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_pc = RV; m_boot = 1'b1; m_halted = 1'b0; m_flush = 1'b0; m_trap = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    FetchReady = 1'b0; Stall = 1'b0; RedirectValid = 1'b0; Halt = 1'b0; Resume = 1'b0;
    RedirectBase = '0; RedirectOffset = '0;
    model_reset();
    #3;
    check("rst_pc", FetchPC, RV);
    check("rst_valid", 32'(FetchValid), 32'd0);
    check("rst_flags", {29'd0, Flush, Halted, Trap}, 32'd0);
    @(posedge clk); #2 reset = 1'b0;

    // Sequential fetch
    cyc(0, 0, 0, 0, 1, 0, 0);
    check("boot_valid", 32'(FetchValid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 1, 0, 0);
      check("seq_pc", FetchPC, 32'(4 * i));
    end

    // Redirect beats a simultaneous handshake
    cyc(1, 32'h10, 32'hFFFF_FFF8, 0, 1, 0, 0);
    check("redir_src_pc", FetchPC, 32'h10);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("redir_pc", FetchPC, 32'h08);
    check("redir_flush", 32'(Flush), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("flush_once", 32'(Flush), 32'd0);

    // Stall and backpressure
    cyc(1, 32'h20, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 1, 0, 0);
      check("stall_valid", 32'(FetchValid), 32'd0);
      check("stall_pc", FetchPC, 32'h20);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("unstall_valid", 32'(FetchValid), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("bp_pc", FetchPC, 32'h20);
    cyc(0, 0, 0, 0, 1, 0, 0);

    // Halt / resume
    cyc(1, 32'h40, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    check("halt_src_pc", FetchPC, 32'h40);
    cyc(0, 0, 0, 0, 1, 0, 0);
    check("halt_state", 32'(Halted), 32'd1);
    check("halt_pc", FetchPC, 32'h44);
    cyc(1, 32'h80, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    check("halt_redir_pc", FetchPC, 32'h80);
    check("halt_redir_state", 32'(Halted), 32'd1);
    cyc(0, 0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    check("resume_valid", 32'(FetchValid), 32'd1);
    check("resume_pc", FetchPC, 32'h80);

    // Wrap
    cyc(1, 32'hFFFF_FFF0, 32'h0C, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    check("wrap_src_pc", FetchPC, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("wrap_pc", FetchPC, 32'h0);

    // Misaligned target
    cyc(1, 32'h100, 32'h2, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("mis_pc", FetchPC, 32'h100);
`ifdef MISALIGN_TRAP_EN
    check("mis_trap", 32'(Trap), 32'd1);
`else
    check("mis_trap", 32'(Trap), 32'd0);
`endif
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] off;
      off = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed($urandom_range(0, 512)) - 256);
      cyc($urandom_range(0, 7) == 0, $urandom, off, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
    end

    // Asynchronous reset between edges with a Flush pending
    cyc(1, 32'h200, 32'h10, 0, 1, 0, 0);
    @(posedge clk); #2;
    check("pre_rst_flush", 32'(Flush), 32'd1);
    reset = 1'b1;
    #1;
    check("async_rst_pc", FetchPC, RV);
    check("async_rst_valid", 32'(FetchValid), 32'd0);
    check("async_rst_flags", {29'd0, Flush, Halted, Trap}, 32'd0);
    model_reset();
    @(posedge clk); #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0, 0);
    check("post_rst_pc", FetchPC, 32'h8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
